line_raster_engine: RTL and testbench

// Parametrised all-octant Bresenham line rasteriser with a start/ready command handshake
// and a valid/ready pixel stream. Sits between drawing control logic and the VGA

---
 rtl/line_raster_pkg.sv | 16 +
 rtl/line_step.sv | 48 ++++
 rtl/line_raster_engine.sv | 154 +++++++++++++++
 tb/tb_line_raster_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_raster_pkg.sv
// Shared types and helpers for the line rasteriser.
package line_raster_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_e;

    // Signed error-term width: enough to hold 2*max(dx,dy) and -2*max(dx,dy).
    function automatic int unsigned calc_err_width(input int unsigned x_w, input int unsigned y_w);
        return ((x_w > y_w) ? x_w : y_w) + 2;
    endfunction

endpackage

// File: rtl/line_step.sv
// Combinational Bresenham step: current point and error term to the next point.
module line_step
    import line_raster_pkg::*;
#(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 9,
    parameter int unsigned E_W = calc_err_width(X_W, Y_W)
) (
    input  logic [X_W-1:0]        cur_x,
    input  logic [Y_W-1:0]        cur_y,
    input  logic [X_W-1:0]        end_x,
    input  logic [Y_W-1:0]        end_y,
    input  logic signed [E_W-1:0] err,
    input  logic signed [E_W-1:0] dx,
    input  logic signed [E_W-1:0] dy,
    input  logic                  sx_neg,
    input  logic                  sy_neg,
    output logic [X_W-1:0]        next_x,
    output logic [Y_W-1:0]        next_y,
    output logic signed [E_W-1:0] next_err,
    output logic                  last
);

    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic signed [E_W-1:0] e2;

    // Both axis decisions use the error term from before this step.
    always_comb begin
        last     = (cur_x == end_x) && (cur_y == end_y);
        e2       = err <<< 1;
        next_x   = cur_x;
        next_y   = cur_y;
        next_err = err;
        if (!last) begin
            if (e2 > -dy) begin
                next_err = next_err - dy;
                next_x   = sx_neg ? (cur_x - X_ONE) : (cur_x + X_ONE);
            end
            if (e2 < dx) begin
                next_err = next_err + dx;
                next_y   = sy_neg ? (cur_y - Y_ONE) : (cur_y + Y_ONE);
            end
        end
    end

endmodule

// File: rtl/line_raster_engine.sv
// All-octant Bresenham line rasteriser with a start/ready command port and a
// valid/ready pixel stream; optional clipping to the visible screen.
module line_raster_engine
    import line_raster_pkg::*;
#(
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned COLOR_W = 1,
    parameter bit          CLIP_EN = 1'b1,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] color,
    output logic               ready,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [X_W-1:0]     pixel_x,
    output logic [Y_W-1:0]     pixel_y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               done
);

    localparam int unsigned E_W = calc_err_width(X_W, Y_W);

    state_e                state;
    logic [X_W-1:0]        end_x;
    logic [Y_W-1:0]        end_y;
    logic signed [E_W-1:0] err;
    logic signed [E_W-1:0] dx;
    logic signed [E_W-1:0] dy;
    logic                  sx_neg;
    logic                  sy_neg;

    logic [X_W-1:0]        next_x;
    logic [Y_W-1:0]        next_y;
    logic signed [E_W-1:0] next_err;
    logic                  last;

    logic [X_W-1:0]        abs_dx;
    logic [Y_W-1:0]        abs_dy;
    logic signed [E_W-1:0] dx_init;
    logic signed [E_W-1:0] dy_init;
    logic                  step;

    function automatic logic on_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        if (!CLIP_EN) begin
            return 1'b1;
        end
        return (32'(px) < H_RES) && (32'(py) < V_RES);
    endfunction

    // Line setup terms; pixel_x/pixel_y already hold the start point during SETUP.
    always_comb begin
        abs_dx  = (end_x >= pixel_x) ? (end_x - pixel_x) : (pixel_x - end_x);
        abs_dy  = (end_y >= pixel_y) ? (end_y - pixel_y) : (pixel_y - end_y);
        dx_init = E_W'(abs_dx);
        dy_init = E_W'(abs_dy);
        // A clipped pixel has pixel_valid low and advances without a handshake.
        step    = pixel_valid ? pixel_ready : 1'b1;
    end

    line_step #(
        .X_W (X_W),
        .Y_W (Y_W),
        .E_W (E_W)
    ) u_line_step (
        .cur_x    (pixel_x),
        .cur_y    (pixel_y),
        .end_x    (end_x),
        .end_y    (end_y),
        .err      (err),
        .dx       (dx),
        .dy       (dy),
        .sx_neg   (sx_neg),
        .sy_neg   (sy_neg),
        .next_x   (next_x),
        .next_y   (next_y),
        .next_err (next_err),
        .last     (last)
    );

    // Control FSM and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            pixel_valid <= 1'b0;
            done        <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= '0;
            end_x       <= '0;
            end_y       <= '0;
            err         <= '0;
            dx          <= '0;
            dy          <= '0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && ready) begin
                        pixel_x     <= x0;
                        pixel_y     <= y0;
                        end_x       <= x1;
                        end_y       <= y1;
                        pixel_color <= color;
                        ready       <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    dx          <= dx_init;
                    dy          <= dy_init;
                    err         <= dx_init - dy_init;
                    sx_neg      <= (end_x < pixel_x);
                    sy_neg      <= (end_y < pixel_y);
                    pixel_valid <= on_screen(pixel_x, pixel_y);
                    state       <= DRAW;
                end
                DRAW: begin
                    if (step) begin
                        if (last) begin
                            pixel_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            pixel_x     <= next_x;
                            pixel_y     <= next_y;
                            err         <= next_err;
                            pixel_valid <= on_screen(next_x, next_y);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: table of lines with hand-computed
// counts/endpoints/done timing, a software Bresenham pixel reference, and a
// mid-line reset sequence.
module tb_line_raster_engine;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 1;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [X_W-1:0]     x0 = '0;
    logic [Y_W-1:0]     y0 = '0;
    logic [X_W-1:0]     x1 = '0;
    logic [Y_W-1:0]     y1 = '0;
    logic [COLOR_W-1:0] color = '0;
    logic               ready;
    logic               pixel_valid;
    logic               pixel_ready = 1'b1;
    logic [X_W-1:0]     pixel_x;
    logic [Y_W-1:0]     pixel_y;
    logic [COLOR_W-1:0] pixel_color;
    logic               done;

    always #5 clk = ~clk;

    line_raster_engine #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W),
        .CLIP_EN (1'b1),
        .H_RES   (H_RES),
        .V_RES   (V_RES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .color       (color),
        .ready       (ready),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .done        (done)
    );

    // One line command plus its hand-computed expectations.
    typedef struct {
        int x0, y0, x1, y1;
        int color;
        bit rand_ready;   // random pixel_ready backpressure
        bit poke;         // random start pulses while busy
        int exp_pix;      // emitted pixel count
        int fx, fy;       // first emitted pixel
        int lx, ly;       // last emitted pixel
        int exp_done;     // cycle of done after the start cycle; -1: check vs last step
    } vec_t;

    typedef struct {
        int x;
        int y;
    } pt_t;

    pt_t  exp_q[$];
    vec_t vecs[9];
    vec_t rst_vec;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(req));
    endtask

    // Software Bresenham reference, keeping only on-screen pixels.
    task automatic build_expected(input vec_t v);
        int x, y, dx, dy, sx, sy, err, e2;
        x   = v.x0;
        y   = v.y0;
        dx  = (v.x1 > v.x0) ? v.x1 - v.x0 : v.x0 - v.x1;
        dy  = (v.y1 > v.y0) ? v.y1 - v.y0 : v.y0 - v.y1;
        sx  = (v.x1 >= v.x0) ? 1 : -1;
        sy  = (v.y1 >= v.y0) ? 1 : -1;
        err = dx - dy;
        exp_q.delete();
        for (int n = 0; n < 5000; n++) begin
            if (x < H_RES && y < V_RES) exp_q.push_back('{x: x, y: y});
            if (x == v.x1 && y == v.y1) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx)  begin err += dx; y += sy; end
        end
    endtask

    task automatic run_line(input vec_t v, input int idx);
        string p;
        int first_cyc, done_cyc, last_acc, n_pix, bad, stall_bad, fx, fy, lx, ly;
        bit held;
        logic [X_W-1:0]     hx;
        logic [Y_W-1:0]     hy;
        logic [COLOR_W-1:0] hc;
        p = $sformatf("line%0d", idx);
        build_expected(v);
        first_cyc = -1; done_cyc = -1; last_acc = -1; n_pix = 0; bad = 0; stall_bad = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; held = 0;
        hx = '0; hy = '0; hc = '0;
        @(negedge clk);
        check({p, "_ready_before_cmd"}, ready, 1);
        x0 = X_W'(v.x0); y0 = Y_W'(v.y0); x1 = X_W'(v.x1); y1 = Y_W'(v.y1);
        color = COLOR_W'(v.color);
        start = 1'b1;
        pixel_ready = 1'b1;
        for (int cyc = 1; cyc < 20000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (v.poke) begin
                start = ($urandom_range(0, 3) == 0);
                x0 = X_W'($urandom); y0 = Y_W'($urandom);
                x1 = X_W'($urandom); y1 = Y_W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (held && (!pixel_valid || pixel_x !== hx || pixel_y !== hy || pixel_color !== hc))
                stall_bad++;
            held = 0;
            pixel_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                done_cyc = cyc;
                start = 1'b0;
                if (pixel_valid) bad++;
            end
            if (pixel_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (pixel_ready) begin
                    if (n_pix >= exp_q.size()) begin
                        bad++;
                    end else if (int'(pixel_x) != exp_q[n_pix].x ||
                                 int'(pixel_y) != exp_q[n_pix].y ||
                                 int'(pixel_color) != v.color) begin
                        if (bad == 0)
                            $display("  %s first bad pixel #%0d: (%0d,%0d) want (%0d,%0d)", p,
                                     n_pix, pixel_x, pixel_y, exp_q[n_pix].x, exp_q[n_pix].y);
                        bad++;
                    end
                    if (n_pix == 0) begin fx = int'(pixel_x); fy = int'(pixel_y); end
                    lx = int'(pixel_x);
                    ly = int'(pixel_y);
                    n_pix++;
                    last_acc = cyc;
                end else begin
                    held = 1;
                    hx = pixel_x; hy = pixel_y; hc = pixel_color;
                end
            end
        end
        start = 1'b0;
        check({p, "_done_seen"}, (done_cyc >= 0), 1);
        check({p, "_pix_count"}, n_pix, v.exp_pix);
        check({p, "_pix_sequence_errors"}, bad, 0);
        check({p, "_stall_hold_errors"}, stall_bad, 0);
        if (v.exp_pix > 0) begin
            check({p, "_first_x"}, fx, v.fx);
            check({p, "_first_y"}, fy, v.fy);
            check({p, "_last_x"}, lx, v.lx);
            check({p, "_last_y"}, ly, v.ly);
        end
        if (v.exp_pix > 0 && v.fx == v.x0 && v.fy == v.y0)
            check({p, "_first_pixel_latency"}, first_cyc, 2);
        if (v.exp_done >= 0) check({p, "_done_cycle"}, done_cyc, v.exp_done);
        else check({p, "_done_after_last_step"}, done_cyc - last_acc, 1);
        @(negedge clk);
        check({p, "_ready_after_done"}, ready, 1);
        check({p, "_done_single_pulse"}, done, 0);
        pixel_ready = 1'b1;
    endtask

    initial begin
        bit seen;
        //          x0   y0   x1   y1  col rr pk  pix   fx   fy   lx   ly  done
        vecs[0] = '{1,   1,   12,  5,  1,  0, 0,  12,   1,   1,   12,  5,  14};
        vecs[1] = '{150, 300, 100, 100, 0, 0, 0,  201,  150, 300, 100, 100, 203};
        vecs[2] = '{5,   5,   5,   5,  1,  0, 0,  1,    5,   5,   5,   5,  3};
        vecs[3] = '{2,   2,   2,   100, 1, 0, 0,  99,   2,   2,   2,   100, 101};
        vecs[4] = '{2,   2,   100, 2,  0,  0, 0,  99,   2,   2,   100, 2,  101};
        vecs[5] = '{0,   0,   639, 479, 1, 1, 1,  640,  0,   0,   639, 479, -1};
        vecs[6] = '{600, 400, 700, 450, 1, 0, 0,  40,   600, 400, 639, 419, 103};
        vecs[7] = '{20,  10,  5,   3,  0,  1, 1,  16,   20,  10,  5,   3,  -1};
        vecs[8] = '{700, 10,  710, 20, 1,  0, 0,  0,    -1,  -1,  -1,  -1, 13};
        rst_vec = '{0,   0,   3,   0,  1,  0, 0,  4,    0,   0,   3,   0,  6};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_pixel_valid", pixel_valid, 0);
        check("reset_done", done, 0);
        check("reset_pixel_x", pixel_x, 0);
        check("reset_pixel_y", pixel_y, 0);
        check("reset_pixel_color", pixel_color, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_line(vecs[i], i);

        // Abandon a long line mid-draw with reset.
        @(negedge clk);
        x0 = '0; y0 = '0; x1 = 10'd100; y1 = '0; color = 1'b1;
        start = 1'b1; pixel_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_in_draw_before_reset", pixel_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_pixel_valid", pixel_valid, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || pixel_valid) seen = 1;
        end
        check("abort_no_done_or_pixels", seen, 0);
        run_line(rst_vec, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
